// File: rtl/timer_scheduler.sv
// Shared millisecond interval timer with round-robin ownership across requesters.
// One prescaler and one tick counter serve all requesters; the winner's duration
// is latched at grant time and a one-cycle done strobe marks expiry.
module timer_scheduler #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned TICK_HZ  = 1000,
    parameter int unsigned DUR_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DUR_W-1:0]     dur,
    output logic [N_REQ-1:0]           grant,
    output logic                       busy,
    output logic [N_REQ-1:0]           done,
    output logic [$clog2(N_REQ)-1:0]   cur_id
);

    localparam int unsigned ID_W = $clog2(N_REQ);
    localparam int unsigned P    = CLK_FREQ / TICK_HZ;
    localparam int unsigned PS_W = (P > 1) ? $clog2(P) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [PS_W-1:0]   prescale;
    logic [DUR_W-1:0]  tick_cnt;
    logic [DUR_W-1:0]  dur_lat;

    logic [ID_W-1:0]   win_id;
    logic [DUR_W-1:0]  win_dur;
    logic              win_found;
    int unsigned       scan_idx;
    logic [ID_W-1:0]   next_rr;
    logic              tick;
    logic              expire;

    // Round-robin pick: first set request searching upward from rr_ptr with wrap.
    always_comb begin
        win_id    = '0;
        win_found = 1'b0;
        scan_idx  = 0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = 32'(rr_ptr) + 32'(k);
            if (scan_idx >= N_REQ) begin
                scan_idx = scan_idx - N_REQ;
            end
            if (!win_found && req[ID_W'(scan_idx)]) begin
                win_found = 1'b1;
                win_id    = ID_W'(scan_idx);
            end
        end
    end

    // Duration field of the current winner.
    always_comb begin
        win_dur = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (win_id == ID_W'(k)) begin
                win_dur = dur[k*DUR_W +: DUR_W];
            end
        end
    end

    // Pointer moves past the requester that just finished or aborted.
    always_comb begin
        if (cur_id == ID_W'(N_REQ - 1)) begin
            next_rr = '0;
        end else begin
            next_rr = cur_id + ID_W'(1);
        end
    end

    assign tick   = (prescale == PS_W'(P - 1));
    assign expire = tick && (tick_cnt == dur_lat - DUR_W'(1));

    // Scheduler FSM with registered outputs; abort wins over a coincident expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            done     <= '0;
            busy     <= 1'b0;
            cur_id   <= '0;
            rr_ptr   <= '0;
            prescale <= '0;
            tick_cnt <= '0;
            dur_lat  <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        cur_id   <= win_id;
                        dur_lat  <= (win_dur == '0) ? DUR_W'(1) : win_dur;
                        prescale <= '0;
                        tick_cnt <= '0;
                        grant    <= N_REQ'(1) << win_id;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (!req[cur_id]) begin
                        grant  <= '0;
                        busy   <= 1'b0;
                        rr_ptr <= next_rr;
                        state  <= IDLE;
                    end else if (expire) begin
                        grant <= '0;
                        done  <= N_REQ'(1) << cur_id;
                        state <= DONE;
                    end else if (tick) begin
                        prescale <= '0;
                        tick_cnt <= tick_cnt + DUR_W'(1);
                    end else begin
                        prescale <= prescale + PS_W'(1);
                    end
                end
                DONE: begin
                    busy   <= 1'b0;
                    rr_ptr <= next_rr;
                    state  <= IDLE;
                end
                default: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler with P = 10 clocks per tick and 4 requesters.
module tb_timer_scheduler;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned DUR_W = 16;

    logic                   clk;
    logic                   rst;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*DUR_W-1:0] dur;
    logic [N_REQ-1:0]       grant;
    logic                   busy;
    logic [N_REQ-1:0]       done;
    logic [1:0]             cur_id;

    int checks;
    int failures;

    timer_scheduler #(
        .N_REQ   (N_REQ),
        .CLK_FREQ(1000),
        .TICK_HZ (100),
        .DUR_W   (DUR_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .dur   (dur),
        .grant (grant),
        .busy  (busy),
        .done  (done),
        .cur_id(cur_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Count consecutive sampled cycles with grant equal to g, current sample included.
    task automatic measure(input logic [N_REQ-1:0] g, output int len);
        len = 1;
        for (int i = 0; i < 500; i++) begin
            cyc();
            if (grant === g) len++;
            else break;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        dur = '0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        dur = '0;
        cyc();
        cyc();
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0 || done !== 4'b0000 || cur_id !== 2'd0) begin
            failures++;
            $display("FAIL reset_state: grant=%b busy=%b done=%b cur_id=%0d, expected 0000/0/0000/0",
                     grant, busy, done, cur_id);
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic saw_done;
        do_reset();
        req = 4'b0001;
        dur[0 +: 16] = 16'd5;
        cyc();
        for (int i = 0; i < 19; i++) cyc();
        checks++;
        if (grant !== 4'b0001 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midrun_before_rst: grant=%b busy=%b, expected 0001/1", grant, busy);
        end
        rst = 1'b1;
        cyc();
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0 || done !== 4'b0000) begin
            failures++;
            $display("FAIL midrun_after_rst: grant=%b busy=%b done=%b, expected 0000/0/0000",
                     grant, busy, done);
        end
        req = '0;
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (done !== 4'b0000) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            failures++;
            $display("FAIL midrun_no_done: saw_done=%b, expected 0", saw_done);
        end
    endtask

    task automatic test_single();
        int len;
        do_reset();
        req = 4'b0100;
        dur[32 +: 16] = 16'd3;
        cyc();
        checks++;
        if (grant !== 4'b0100 || cur_id !== 2'd2 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_grant: grant=%b cur_id=%0d busy=%b, expected 0100/2/1",
                     grant, cur_id, busy);
        end
        measure(4'b0100, len);
        checks++;
        if (len !== 30) begin
            failures++;
            $display("FAIL single_len: got %0d cycles, expected 30", len);
        end
        checks++;
        if (done !== 4'b0100 || busy !== 1'b1 || grant !== 4'b0000) begin
            failures++;
            $display("FAIL single_done: done=%b busy=%b grant=%b, expected 0100/1/0000",
                     done, busy, grant);
        end
        req = '0;
        cyc();
        checks++;
        if (done !== 4'b0000 || busy !== 1'b0 || cur_id !== 2'd2) begin
            failures++;
            $display("FAIL single_after: done=%b busy=%b cur_id=%0d, expected 0000/0/2",
                     done, busy, cur_id);
        end
    endtask

    task automatic test_round_robin();
        logic [N_REQ-1:0] order [4];
        int len;
        order[0] = 4'b0001;
        order[1] = 4'b0010;
        order[2] = 4'b1000;
        order[3] = 4'b0001;
        do_reset();
        req = 4'b1011;
        dur = {16'd1, 16'd1, 16'd1, 16'd1};
        for (int i = 0; i < 4; i++) begin
            if (i != 0) begin
                cyc();
                checks++;
                if (grant !== 4'b0000 || done !== 4'b0000) begin
                    failures++;
                    $display("FAIL rr_gap%0d: grant=%b done=%b, expected 0000/0000", i, grant, done);
                end
            end
            cyc();
            checks++;
            if (grant !== order[i]) begin
                failures++;
                $display("FAIL rr_grant%0d: grant=%b, expected %b", i, grant, order[i]);
            end
            measure(order[i], len);
            checks++;
            if (len !== 10 || done !== order[i]) begin
                failures++;
                $display("FAIL rr_len%0d: len=%0d done=%b, expected 10/%b", i, len, done, order[i]);
            end
        end
        req = '0;
        cyc();
    endtask

    task automatic test_dur_zero();
        int len;
        do_reset();
        req = 4'b0010;
        dur[16 +: 16] = 16'd0;
        cyc();
        checks++;
        if (grant !== 4'b0010) begin
            failures++;
            $display("FAIL dur0_grant: grant=%b, expected 0010", grant);
        end
        measure(4'b0010, len);
        checks++;
        if (len !== 10 || done !== 4'b0010) begin
            failures++;
            $display("FAIL dur0_len: len=%0d done=%b, expected 10/0010", len, done);
        end
        req = '0;
        cyc();
    endtask

    task automatic test_abort();
        logic saw_done;
        do_reset();
        req = 4'b1000;
        dur[48 +: 16] = 16'd4;
        cyc();
        checks++;
        if (grant !== 4'b1000 || cur_id !== 2'd3) begin
            failures++;
            $display("FAIL abort_grant: grant=%b cur_id=%0d, expected 1000/3", grant, cur_id);
        end
        req = 4'b1110;
        saw_done = 1'b0;
        for (int i = 0; i < 14; i++) begin
            cyc();
            if (done !== 4'b0000) saw_done = 1'b1;
        end
        checks++;
        if (grant !== 4'b1000 || saw_done !== 1'b0) begin
            failures++;
            $display("FAIL abort_hold: grant=%b saw_done=%b, expected 1000/0", grant, saw_done);
        end
        req = 4'b0110;
        cyc();
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0 || done !== 4'b0000 || cur_id !== 2'd3) begin
            failures++;
            $display("FAIL abort_drop: grant=%b busy=%b done=%b cur_id=%0d, expected 0000/0/0000/3",
                     grant, busy, done, cur_id);
        end
        cyc();
        checks++;
        if (grant !== 4'b0010 || cur_id !== 2'd1 || done !== 4'b0000) begin
            failures++;
            $display("FAIL abort_next: grant=%b cur_id=%0d done=%b, expected 0010/1/0000",
                     grant, cur_id, done);
        end
        req = '0;
        cyc();
    endtask

    task automatic test_dur_change();
        int n;
        do_reset();
        req = 4'b0001;
        dur[0 +: 16] = 16'd2;
        cyc();
        n = 1;
        for (int i = 0; i < 500; i++) begin
            cyc();
            if (grant === 4'b0001) n++;
            else break;
            if (n == 5) dur[0 +: 16] = 16'd9;
        end
        checks++;
        if (n !== 20 || done !== 4'b0001) begin
            failures++;
            $display("FAIL durchg_len: len=%0d done=%b, expected 20/0001", n, done);
        end
        req = '0;
        cyc();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        req = '0;
        dur = '0;
        test_reset();
        test_reset_mid_run();
        test_single();
        test_round_robin();
        test_dur_zero();
        test_abort();
        test_dur_change();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_scheduler.md
Name: timer_scheduler

Overview:
Shared time-base scheduler. N requesters contend for one prescaled millisecond interval timer instead of each instantiating a wide free-running counter. A round-robin arbiter grants the timer to one requester and counts that requester's programmed duration. On expiry it pulses a per-requester done strobe. Sits beside the LED/blink and delay logic as the single owner of long-interval counting.

Parameters:
N_REQ, 4, number of requesters (2..8)
CLK_FREQ, 50_000_000, system clock frequency in Hz
TICK_HZ, 1000, timer tick rate (1 ms); P = CLK_FREQ/TICK_HZ clocks per tick; CLK_FREQ must be an exact multiple of TICK_HZ
DUR_W, 16, width of each duration field, in ticks

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
req  in  N_REQ  per-requester request level; held until done or abort
dur  in  N_REQ*DUR_W  packed durations in ticks; requester i uses bits [i*DUR_W +: DUR_W]
grant  out  N_REQ  one-hot; high while requester owns the running timer
busy  out  1  timer running (RUN or DONE state)
done  out  N_REQ  one-hot single-cycle expiry strobe
cur_id  out  clog2(N_REQ)  index of current or last granted requester

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, grant=0, done=0, busy=0, cur_id=0, rr pointer=0, prescaler=0, tick counter=0. Reset takes priority over all events and aborts any running interval; no done is issued.
- FSM states: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - If any req bit is set, select the winner round-robin: the first set bit searching upward from the rr pointer, wrapping at N_REQ-1.
  - Latch cur_id=winner and dur_lat=dur[winner]; a latched value of 0 is treated as 1.
  - Clear prescaler and tick counter. Next state=RUN; grant[winner]=1 in the first RUN cycle.
- RUN:
  - Prescaler counts 0..P-1 and wraps; tick occurs when prescaler==P-1.
  - Tick counter increments on each tick; width DUR_W, no overflow is possible because the count ends at dur_lat-1.
  - Expiry: tick and tick counter==dur_lat-1 -> next state DONE. RUN lasts exactly dur_lat*P cycles.
  - Abort: req[cur_id]==0 in any RUN cycle -> next state IDLE, grant cleared, no done; rr pointer is still advanced to cur_id+1.
  - dur changes during RUN are ignored; the value latched in IDLE is used.
  - Requests from other requesters are ignored until the timer returns to IDLE.
- DONE:
  - Lasts one cycle. done[cur_id]=1, grant=0, busy=1.
  - rr pointer=cur_id+1 mod N_REQ. Next state=IDLE.
- busy=1 in RUN and DONE.
- Latency:
  - req sampled in IDLE -> grant high on the next cycle.
  - done high dur_lat*P cycles after the first grant cycle.
  - Earliest next grant is the cycle after DONE (IDLE cycle + 1).
- Requester owns dropping req. If req[cur_id] is still high in the IDLE cycle after DONE, it is re-arbitrated; round-robin ordering lets other pending requesters win first.
- Simultaneous req rising with abort or expiry: only the IDLE state samples req, so there is no same-cycle handover.
- cur_id holds its value after DONE/abort until the next grant.

Test Plan (CLK_FREQ=1000, TICK_HZ=100, so P=10; N_REQ=4):
1. Reset mid-RUN: req[0]=1, dur0=5, assert rst at cycle 20 -> next cycle grant=0, busy=0, done=0; done[0] never pulses.
2. Single request: req[2]=1, dur2=3 -> grant=4'b0100 one cycle later for exactly 30 cycles, then done=4'b0100 for 1 cycle; cur_id=2.
3. Round-robin: req=4'b1011 held, all dur=1 -> grant order 0,1,3,0. Each grant lasts 10 cycles, separated by DONE+IDLE cycles.
4. dur=0: req[1]=1, dur1=0 -> grant lasts 10 cycles (treated as 1), then done[1] pulses.
5. Abort: req[3]=1, dur3=4; drop req[3] at grant cycle 15 -> grant low next cycle, no done[3], busy=0; next grant goes to lowest pending index searching from 0.
6. dur change during RUN: dur0=2 latched, dur0 changed to 9 at grant cycle 5 -> done[0] still pulses after 20 grant cycles.
